// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling ratio,
// data width and the baud-tick divider calculation.
package uart_pkg;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_e;

    // Clock cycles per oversampling tick, truncated.
    function automatic int unsigned tick_div(input int unsigned clk_freq,
                                             input int unsigned baud);
        return clk_freq / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: counts 0..TICK_DIV-1 and emits a one-cycle
// tick on the last count. A synchronous clear holds the count at zero.
module uart_baud_tick #(
    parameter int unsigned TICK_DIV = 651
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] count_q, count_d;
    logic            wrap;

    assign wrap = (count_q == CntLast);
    assign tick = wrap & ~clear;

    // Next count: hold at zero while cleared, wrap after the last count.
    always_comb begin
        count_d = count_q;
        if (clear || wrap) begin
            count_d = '0;
        end else begin
            count_d = count_q + CntW'(1);
        end
    end

    // Divider count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: 8N1 (8E1 with UART_RX_PARITY_EN defined), 16x oversampling,
// mid-bit sampling, single-entry output register held until rx_ack.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BAUD     = 9600
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RxD,
    input  logic              rx_ack,
    output logic [DATA_W-1:0] data,
    output logic              rx_valid,
    output logic              busy,
    output logic              frame_err,
    output logic              overrun_err,
    output logic              parity_err
);

    localparam int unsigned TickDiv  = tick_div(CLK_FREQ, BAUD);
    localparam logic [3:0]  TickLast = 4'(OVERSAMPLE - 1);
    localparam logic [3:0]  TickMid  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [2:0]  BitLast  = 3'(DATA_W - 1);

    uart_state_e       state_q, state_d;
    logic              sync1_q, rx_s_q, rx_prev_q;
    logic [3:0]        tick_cnt_q, tick_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              busy_q, busy_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_err_q, overrun_err_d;
    logic              tick, clear, fall;
`ifdef UART_RX_PARITY_EN
    logic              par_bad_q, par_bad_d;
    logic              parity_err_q, parity_err_d;
`endif

    // Divider runs only while a frame is in progress.
    assign clear = (state_q == StIdle);
    assign fall  = rx_prev_q & ~rx_s_q;

    uart_baud_tick #(
        .TICK_DIV(TickDiv)
    ) u_baud_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(clear),
        .tick (tick)
    );

    // Frame FSM next state, shift register and output register updates.
    always_comb begin
        state_d       = state_q;
        tick_cnt_d    = tick_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        data_d        = data_q;
        rx_valid_d    = rx_valid_q & ~rx_ack;
        frame_err_d   = 1'b0;
        overrun_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d     = par_bad_q;
        parity_err_d  = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (fall) begin
                    state_d    = StStart;
                    tick_cnt_d = '0;
                end
            end
            StStart: begin
                if (tick) begin
                    if (tick_cnt_q == TickMid) begin
                        // Line back high at mid start bit: treat as glitch.
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = rx_s_q ? StIdle : StData;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
            StData: begin
                if (tick) begin
                    if (tick_cnt_q == TickLast) begin
                        tick_cnt_d = '0;
                        shift_d    = {rx_s_q, shift_q[DATA_W-1:1]};
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == BitLast) begin
`ifdef UART_RX_PARITY_EN
                            state_d = StParity;
`else
                            state_d = StStop;
`endif
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (tick) begin
                    if (tick_cnt_q == TickLast) begin
                        tick_cnt_d = '0;
                        par_bad_d  = (^shift_q) ^ rx_s_q;
                        state_d    = StStop;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
`endif
            StStop: begin
                if (tick) begin
                    if (tick_cnt_q == TickLast) begin
                        tick_cnt_d = '0;
                        state_d    = StIdle;
                        if (rx_s_q) begin
                            // Load wins over a coincident ack.
                            data_d        = shift_q;
                            rx_valid_d    = 1'b1;
                            overrun_err_d = rx_valid_q & ~rx_ack;
                        end else begin
                            frame_err_d = 1'b1;
                        end
`ifdef UART_RX_PARITY_EN
                        parity_err_d = par_bad_q;
`endif
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    // Synchronizer, edge register, FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q       <= 1'b1;
            rx_s_q        <= 1'b1;
            rx_prev_q     <= 1'b1;
            state_q       <= StIdle;
            tick_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            data_q        <= '0;
            rx_valid_q    <= 1'b0;
            busy_q        <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q     <= 1'b0;
            parity_err_q  <= 1'b0;
`endif
        end else begin
            sync1_q       <= RxD;
            rx_s_q        <= sync1_q;
            rx_prev_q     <= rx_s_q;
            state_q       <= state_d;
            tick_cnt_q    <= tick_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            data_q        <= data_d;
            rx_valid_q    <= rx_valid_d;
            busy_q        <= busy_d;
            frame_err_q   <= frame_err_d;
            overrun_err_q <= overrun_err_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q     <= par_bad_d;
            parity_err_q  <= parity_err_d;
`endif
        end
    end

    assign data        = data_q;
    assign rx_valid    = rx_valid_q;
    assign busy        = busy_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_err_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err  = parity_err_q;
`else
    assign parity_err  = 1'b0;
`endif

endmodule
